// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences instruction phases,
// drives datapath selects/strobes, and traps illegal opcodes and memory timeouts.
module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
    S_TRAP   = 4'd12, S_ERROR  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               timeout_s;
  logic               retire_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_s = (MEM_TIMEOUT > 0) && (wait_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timeout_s) state_d = S_ERROR;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = S_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        // IR is stable here, so anything other than lw/sw means a corrupted decode
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_TRAP;
      end
      S_MEMRD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (timeout_s) state_d = S_ERROR;
        else                state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timeout_s) state_d = S_ERROR;
        else                state_d = S_MEMWR;
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP: state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_TRAP:   state_d = S_TRAP;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    // wait counter runs only while a memory state is held waiting; any move or ready clears it
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) &&
        (state_d == state_q) && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end

    retire_s  = (state_d == S_FETCH) &&
                (state_q == S_MEMWB || state_q == S_MEMWR || state_q == S_ALUWB ||
                 state_q == S_BRANCH || state_q == S_IWB || state_q == S_JUMP);
    if (retire_s) retired_d = retired_q + CNT_W'(1);
    else          retired_d = retired_q;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b000;
    illegal     = 1'b0;
    mem_err     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (opcode)
            OP_ANDI: ALUOp = 3'b011;
            OP_ORI:  ALUOp = 3'b110;
            OP_SLTI: ALUOp = 3'b111;
            default: ALUOp = 3'b000;
          endcase
        end
        S_IWB:   RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_TRAP:  illegal = 1'b1;
        S_ERROR: mem_err = 1'b1;
        default: mem_err = 1'b0;
      endcase
    end else begin
      illegal = 1'b0;
    end
  end

  assign pc_en   = PCWrite | (PCWriteCond & zero);
  assign state   = reset ? 4'd0 : state_q;
  assign retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized instruction-level bench: builds expected per-cycle state/output plans from
// instruction templates and checks the control FSM against them.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  opcode;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        pc_en, illegal, mem_err;
  logic [3:0]  state;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;
  int m_ret = 0;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    logic [5:0] opc;
    logic       rst;
    logic       ret;
  } step_t;

  step_t plan[$];

  multicycle_main_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .pc_en(pc_en), .state(state), .illegal(illegal), .mem_err(mem_err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Expected control word for a state, straight from the state/output table.
  function automatic logic [19:0] exp_out(logic [3:0] st, logic [5:0] opc, logic rdy, logic z, logic rst);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, me;
    logic [1:0] sb, ps;
    logic [2:0] op;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, me} = 12'd0;
    sb = 2'b00; ps = 2'b00; op = 3'b000;
    if (!rst) begin
      case (st)
        4'd0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
        4'd1:  sb = 2'b11;
        4'd2:  begin sa = 1'b1; sb = 2'b10; end
        4'd3:  begin mr = 1'b1; iord = 1'b1; end
        4'd4:  begin rw = 1'b1; m2r = 1'b1; end
        4'd5:  begin mw = 1'b1; iord = 1'b1; end
        4'd6:  begin sa = 1'b1; op = 3'b010; end
        4'd7:  begin rw = 1'b1; rd = 1'b1; end
        4'd8:  begin sa = 1'b1; op = 3'b001; pcwc = 1'b1; ps = 2'b01; end
        4'd9:  begin
          sa = 1'b1; sb = 2'b10;
          op = (opc == 6'b001100) ? 3'b011 : (opc == 6'b001101) ? 3'b110 :
               (opc == 6'b001010) ? 3'b111 : 3'b000;
        end
        4'd10: rw = 1'b1;
        4'd11: begin pcw = 1'b1; ps = 2'b10; end
        4'd12: ill = 1'b1;
        4'd13: me = 1'b1;
        default: ill = 1'b0;
      endcase
    end
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, op, pcw | (pcwc & z), ill, me};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic rdy, input logic z, input logic [5:0] opc,
                     input logic rst, input logic ret);
    step_t s;
    s.st = st; s.rdy = rdy; s.z = z; s.opc = opc; s.rst = rst; s.ret = ret;
    plan.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle plan: fetch waits, decode, then the opcode's phases.
  task automatic push_instr(input logic [5:0] opc, input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) add(4'd0, 1'b0, z, opc, 1'b0, 1'b0);
    add(4'd0, 1'b1, z, opc, 1'b0, 1'b0);
    add(4'd1, rbit(), z, opc, 1'b0, 1'b0);
    case (opc)
      6'b100011: begin
        add(4'd2, rbit(), z, opc, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) add(4'd3, 1'b0, z, opc, 1'b0, 1'b0);
        add(4'd3, 1'b1, z, opc, 1'b0, 1'b0);
        add(4'd4, rbit(), z, opc, 1'b0, 1'b1);
      end
      6'b101011: begin
        add(4'd2, rbit(), z, opc, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) add(4'd5, 1'b0, z, opc, 1'b0, 1'b0);
        add(4'd5, 1'b1, z, opc, 1'b0, 1'b1);
      end
      6'b000000: begin
        add(4'd6, rbit(), z, opc, 1'b0, 1'b0);
        add(4'd7, rbit(), z, opc, 1'b0, 1'b1);
      end
      6'b000100: add(4'd8, rbit(), z, opc, 1'b0, 1'b1);
      6'b000010: add(4'd11, rbit(), z, opc, 1'b0, 1'b1);
      default: begin
        add(4'd9, rbit(), z, opc, 1'b0, 1'b0);
        add(4'd10, rbit(), z, opc, 1'b0, 1'b1);
      end
    endcase
  endtask

  task automatic run_plan();
    step_t s;
    logic [19:0] obs;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      reset = s.rst; opcode = s.opc; zero = s.z; mem_ready = s.rdy;
      #1;
      obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
             ALUSrcA, ALUSrcB, PCSource, ALUOp, pc_en, illegal, mem_err};
      check("state", {28'd0, state}, s.rst ? 32'd0 : {28'd0, s.st});
      check("outs", {12'd0, obs}, {12'd0, exp_out(s.st, s.opc, s.rdy, s.z, s.rst)});
      check("retired", retired, s.rst ? 32'd0 : m_ret);
      @(posedge clk);
      if (s.rst) m_ret = 0;
      else if (s.ret) m_ret++;
    end
  endtask

  logic [5:0] legal [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                            6'b001100, 6'b001101, 6'b001010, 6'b000010};

  initial begin
    reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    add(4'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    add(4'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    push_instr(6'b100011, 1'b0, 0, 0);
    push_instr(6'b000000, 1'b0, 0, 0);
    push_instr(6'b000100, 1'b1, 0, 0);
    push_instr(6'b000100, 1'b0, 0, 0);
    push_instr(6'b100011, 1'b0, 3, 0);
    push_instr(6'b101011, 1'b1, 0, 4);
    for (int n = 0; n < 50; n++)
      push_instr(legal[$urandom_range(0, 8)], rbit(), $urandom_range(0, 4), $urandom_range(0, 4));
    run_plan();

    // memory read never completes: five cycles in MEMRD, then absorbing ERROR
    add(4'd0, 1'b1, 1'b0, 6'b100011, 1'b0, 1'b0);
    add(4'd1, 1'b1, 1'b0, 6'b100011, 1'b0, 1'b0);
    add(4'd2, 1'b1, 1'b0, 6'b100011, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(4'd3, 1'b0, 1'b0, 6'b100011, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(4'd13, rbit(), 1'b1, 6'b100011, 1'b0, 1'b0);
    add(4'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    // fetch timeout boundary
    for (int i = 0; i < 5; i++) add(4'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    add(4'd13, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    add(4'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    // illegal opcode
    add(4'd0, 1'b1, 1'b0, 6'b111111, 1'b0, 1'b0);
    add(4'd1, 1'b1, 1'b0, 6'b111111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(4'd12, rbit(), 1'b1, 6'b111111, 1'b0, 1'b0);
    add(4'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    // reset while in EXEC discards the instruction and clears the count
    push_instr(6'b001101, 1'b0, 1, 0);
    push_instr(6'b000010, 1'b0, 0, 0);
    add(4'd0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0);
    add(4'd1, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0);
    add(4'd6, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0);
    push_instr(6'b000010, 1'b0, 0, 0);
    run_plan();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
